// File: rtl/tinynpu_pkg.sv
// rtl/tinynpu_pkg.sv - shared TinyNPU encodings for controller and host sequencer
package tinynpu_pkg;

   // Controller state as reported on npu_state
   typedef enum logic [1:0] {
      NPU_LD0 = 2'b00,
      NPU_MAC = 2'b01,
      NPU_LD1 = 2'b10,
      NPU_OUT = 2'b11
   } npu_state_e;

   // Host command opcodes
   typedef enum logic [1:0] {
      OP_LDX = 2'b00,
      OP_LDW = 2'b01,
      OP_RUN = 2'b10,
      OP_FIN = 2'b11
   } cmd_op_e;

   // Host sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_XFER   = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_FINISH = 3'd3,
      ST_HALT   = 3'd4
   } seq_state_e;

endpackage

// File: rtl/tinynpu_host_seq_reg.sv
// rtl/tinynpu_host_seq_reg.sv - generic register with load enable and synchronous clear
module tinynpu_host_seq_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear wins over load so a new command always starts from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/tinynpu_host_seq.sv
// rtl/tinynpu_host_seq.sv - host command sequencer driving TinyNPU loads and launches
module tinynpu_host_seq
   import tinynpu_pkg::*;
#(
   parameter int SIZE = 4,
   parameter int DW   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_val,
   output logic                    cmd_rdy,
   input  logic [1:0]              cmd_op,
   input  logic [$clog2(SIZE)-1:0] cmd_sel,
   input  logic                    data_val,
   output logic                    data_rdy,
   input  logic [DW-1:0]           data,
   input  logic [1:0]              npu_state,
   output logic                    x_load_val,
   output logic                    w_load_val,
   output logic [$clog2(SIZE)-1:0] w_load_sel,
   output logic [DW-1:0]           load_data,
   output logic                    mac_val,
   output logic                    out_val,
   output logic                    busy,
   output logic                    err
);

   localparam int SW = $clog2(SIZE);
   localparam int CW = SW + 1;

   seq_state_e      state;
   logic            mode_w;
   logic [SW-1:0]   row_q;
   logic [CW-1:0]   cnt;
   logic            ldwin;
   logic            cmd_hs;
   logic            data_hs;
   logic            last_word;

   // Loads are only legal while the controller sits in one of its load phases
   always_comb begin
      ldwin     = (npu_state == NPU_LD0) || (npu_state == NPU_LD1);
      cmd_rdy   = !rst && (state == ST_IDLE) && ldwin;
      data_rdy  = !rst && (state == ST_XFER) && ldwin;
      cmd_hs    = cmd_val && cmd_rdy;
      data_hs   = data_val && data_rdy;
      last_word = (cnt == CW'(SIZE - 1));
      busy      = (state != ST_IDLE);
   end

   // Word counter: cleared by every accepted command, advanced per data word
   tinynpu_host_seq_reg #(.W(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (data_hs),
      .clr (cmd_hs),
      .d   (cnt + CW'(1)),
      .q   (cnt)
   );

   // Sequencer FSM with registered strobes and launch/finish levels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         mode_w     <= 1'b0;
         row_q      <= '0;
         x_load_val <= 1'b0;
         w_load_val <= 1'b0;
         w_load_sel <= '0;
         load_data  <= '0;
         mac_val    <= 1'b0;
         out_val    <= 1'b0;
         err        <= 1'b0;
      end else begin
         x_load_val <= 1'b0;
         w_load_val <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_hs) begin
                  case (cmd_op)
                     OP_LDX: begin
                        // In LD1 the x FIFO belongs to the array output stream
                        if (npu_state == NPU_LD0) begin
                           mode_w <= 1'b0;
                           state  <= ST_XFER;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OP_LDW: begin
                        mode_w <= 1'b1;
                        row_q  <= cmd_sel;
                        state  <= ST_XFER;
                     end
                     OP_RUN: begin
                        mac_val <= 1'b1;
                        state   <= ST_LAUNCH;
                     end
                     default: begin
                        out_val <= 1'b1;
                        state   <= ST_FINISH;
                     end
                  endcase
               end
            end
            ST_XFER: begin
               if (data_hs) begin
                  if (mode_w) begin
                     w_load_val <= 1'b1;
                     w_load_sel <= row_q;
                  end else begin
                     x_load_val <= 1'b1;
                  end
                  load_data <= data;
                  if (last_word)
                     state <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               // Hold the launch until MAC is seen, then wait for MAC to end
               if (mac_val) begin
                  if (npu_state == NPU_MAC)
                     mac_val <= 1'b0;
               end else if (npu_state != NPU_MAC) begin
                  state <= ST_IDLE;
               end
            end
            ST_FINISH: begin
               if (npu_state == NPU_OUT) begin
                  out_val <= 1'b0;
                  state   <= ST_HALT;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tinynpu_host_seq.sv
// tb/tb_tinynpu_host_seq.sv - directed self-checking bench for tinynpu_host_seq
module tb_tinynpu_host_seq;

   localparam logic [1:0] LD0 = 2'b00;
   localparam logic [1:0] MAC = 2'b01;
   localparam logic [1:0] LD1 = 2'b10;
   localparam logic [1:0] OUT = 2'b11;
   localparam logic [1:0] LDX = 2'b00;
   localparam logic [1:0] LDW = 2'b01;
   localparam logic [1:0] RUN = 2'b10;
   localparam logic [1:0] FIN = 2'b11;

   logic       clk;
   logic       rst;
   logic       cmd_val;
   logic       cmd_rdy;
   logic [1:0] cmd_op;
   logic [1:0] cmd_sel;
   logic       data_val;
   logic       data_rdy;
   logic [7:0] data;
   logic [1:0] npu_state;
   logic       x_load_val;
   logic       w_load_val;
   logic [1:0] w_load_sel;
   logic [7:0] load_data;
   logic       mac_val;
   logic       out_val;
   logic       busy;
   logic       err;

   int tests = 0;
   int fails = 0;

   logic       dv3 [0:10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [1:0] ns3 [0:10] = '{LD0, LD0, LD0, MAC, MAC, MAC, LD1, LD1, LD1, LD1, LD1};
   logic [1:0] ns4 [0:8]  = '{LD0, LD0, MAC, MAC, MAC, MAC, MAC, LD1, LD1};
   logic [1:0] ns6 [0:4]  = '{LD1, LD1, LD1, OUT, OUT};

   tinynpu_host_seq #(.SIZE(4), .DW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_val    (cmd_val),
      .cmd_rdy    (cmd_rdy),
      .cmd_op     (cmd_op),
      .cmd_sel    (cmd_sel),
      .data_val   (data_val),
      .data_rdy   (data_rdy),
      .data       (data),
      .npu_state  (npu_state),
      .x_load_val (x_load_val),
      .w_load_val (w_load_val),
      .w_load_sel (w_load_sel),
      .load_data  (load_data),
      .mac_val    (mac_val),
      .out_val    (out_val),
      .busy       (busy),
      .err        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int w;
      logic hs;
      logic exp_rdy;

      rst       = 1'b1;
      cmd_val   = 1'b1;
      cmd_op    = RUN;
      cmd_sel   = 2'd0;
      data_val  = 1'b0;
      data      = 8'd0;
      npu_state = LD0;

      // Reset held with a pending command
      tick();
      tick();
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
      chk("rst_data_rdy", 32'(data_rdy), 32'd0);
      chk("rst_strobes", {30'd0, x_load_val, w_load_val}, 32'd0);
      chk("rst_levels", {30'd0, mac_val, out_val}, 32'd0);
      chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
      chk("rst_sel_data", {22'd0, w_load_sel, load_data}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
      cmd_val = 1'b0;

      // LDX in LD0 with four back-to-back words
      tick();
      cmd_val = 1'b1;
      cmd_op  = LDX;
      tick();
      cmd_val = 1'b0;
      chk("ldx_busy", 32'(busy), 32'd1);
      chk("ldx_data_rdy", 32'(data_rdy), 32'd1);
      chk("ldx_no_early_strobe", 32'(x_load_val), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         data_val = 1'b1;
         data     = 8'(i);
         tick();
         chk("ldx_strobe", 32'(x_load_val), 32'd1);
         chk("ldx_no_w", 32'(w_load_val), 32'd0);
         chk("ldx_data", 32'(load_data), 32'(i));
      end
      data_val = 1'b0;
      chk("ldx_idle", 32'(busy), 32'd0);
      tick();
      chk("ldx_strobe_off", 32'(x_load_val), 32'd0);

      // LDW row 2 with data gaps and a load-window drop
      cmd_val = 1'b1;
      cmd_op  = LDW;
      cmd_sel = 2'd2;
      tick();
      cmd_val = 1'b0;
      cmd_sel = 2'd0;
      w = 0;
      for (int i = 0; i < 11; i++) begin
         data_val  = dv3[i];
         npu_state = ns3[i];
         data      = 8'(9 + w);
         exp_rdy   = ((ns3[i] == LD0) || (ns3[i] == LD1)) && (w < 4);
         hs        = dv3[i] && exp_rdy;
         #1;
         chk("ldw_data_rdy", 32'(data_rdy), 32'(exp_rdy));
         tick();
         chk("ldw_strobe", 32'(w_load_val), 32'(hs));
         chk("ldw_no_x", 32'(x_load_val), 32'd0);
         if (hs) begin
            chk("ldw_data", 32'(load_data), 32'(9 + w));
            chk("ldw_sel", 32'(w_load_sel), 32'd2);
            w++;
         end
      end
      data_val = 1'b0;
      chk("ldw_idle", 32'(busy), 32'd0);

      // RUN: launch held until MAC is sampled, idle once MAC ends
      npu_state = LD0;
      cmd_val   = 1'b1;
      cmd_op    = RUN;
      #1;
      chk("run_cmd_rdy", 32'(cmd_rdy), 32'd1);
      tick();
      cmd_val = 1'b0;
      for (int i = 0; i < 9; i++) begin
         npu_state = ns4[i];
         #1;
         chk("run_mac_val", 32'(mac_val), 32'(i < 3));
         chk("run_out_val", 32'(out_val), 32'd0);
         chk("run_busy", 32'(busy), 32'(i < 8));
         tick();
      end

      // LDX in LD1 is consumed as an error; a later LDW still works
      npu_state = LD1;
      cmd_val   = 1'b1;
      cmd_op    = LDX;
      #1;
      chk("bad_ldx_cmd_rdy", 32'(cmd_rdy), 32'd1);
      tick();
      cmd_val = 1'b0;
      chk("bad_ldx_err", 32'(err), 32'd1);
      chk("bad_ldx_busy", 32'(busy), 32'd0);
      chk("bad_ldx_no_strobe", {30'd0, x_load_val, w_load_val}, 32'd0);
      tick();
      chk("bad_ldx_err_sticky", 32'(err), 32'd1);
      cmd_val = 1'b1;
      cmd_op  = LDW;
      cmd_sel = 2'd1;
      tick();
      cmd_val = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_val = 1'b1;
         data     = 8'(8'h20 + i);
         tick();
         chk("ldw2_strobe", 32'(w_load_val), 32'd1);
         chk("ldw2_data", 32'(load_data), 32'(8'h20 + i));
         chk("ldw2_sel", 32'(w_load_sel), 32'd1);
      end
      data_val = 1'b0;
      chk("ldw2_idle", 32'(busy), 32'd0);
      chk("ldw2_err_sticky", 32'(err), 32'd1);

      // FIN in LD1: finish level held until OUT, then terminal halt
      cmd_val = 1'b1;
      cmd_op  = FIN;
      tick();
      cmd_val = 1'b0;
      for (int i = 0; i < 5; i++) begin
         npu_state = ns6[i];
         #1;
         chk("fin_out_val", 32'(out_val), 32'(i < 4));
         chk("fin_mac_val", 32'(mac_val), 32'd0);
         chk("fin_busy", 32'(busy), 32'd1);
         tick();
      end
      npu_state = LD0;
      cmd_val   = 1'b1;
      cmd_op    = LDX;
      #1;
      chk("halt_cmd_rdy", 32'(cmd_rdy), 32'd0);
      chk("halt_data_rdy", 32'(data_rdy), 32'd0);
      tick();
      chk("halt_no_strobe", 32'(x_load_val), 32'd0);
      chk("halt_busy", 32'(busy), 32'd1);

      // Asynchronous reset out of halt
      rst = 1'b1;
      #1;
      chk("rst2_busy", 32'(busy), 32'd0);
      chk("rst2_err", 32'(err), 32'd0);
      chk("rst2_cmd_rdy", 32'(cmd_rdy), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst2_cmd_rdy_after", 32'(cmd_rdy), 32'd1);
      cmd_val = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
